// File: rtl/mem_stage_lsu_pkg.sv
// Shared RV32I memory-stage types: load/store funct3 encodings and the LSU state.
package mem_stage_lsu_pkg;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        ST_SB = 3'b000,
        ST_SH = 3'b001,
        ST_SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Picks the addressed byte/halfword out of a memory word and sign- or zero-extends it.
module lsu_load_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        data    = rdata;
        case (funct3)
            LD_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            LD_LBU:  data = {24'b0, shifted[7:0]};
            LD_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            LD_LHU:  data = {16'b0, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: formats the data-memory request, stalls the pipe
// until the response (or timeout) and returns the extended load value.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        done_o,
    output logic        err_o,
    output lsu_state_t  lsu_state
);

    // Handshake: a request is held (read/write high, address/mask/data stable)
    // from the first REQ cycle until the cycle in which dmem_resp is seen high.
    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state, state_n;
    logic        req, bad, misaligned, unsupported;
    logic [1:0]  off;
    logic [3:0]  wmask_n;
    logic [31:0] wdata_n;
    logic        accept, finish, timeout, tmo_hit, tmo_err;
    logic [31:0] tmo_cnt;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] aligned;

    assign req       = valid_i & (mem_read_i | mem_write_i);
    assign off       = addr_i[1:0];
    assign bad       = misaligned | unsupported;
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);
    assign lsu_state = state;

    // A write wins over a simultaneous read, so decode as a store whenever mem_write_i is set.
    always_comb begin
        misaligned  = 1'b0;
        unsupported = 1'b0;
        wmask_n     = 4'b0000;
        wdata_n     = 32'b0;
        if (mem_write_i) begin
            case (funct3_i)
                ST_SB: begin
                    wmask_n = 4'b0001 << off;
                    wdata_n = {4{store_data_i[7:0]}};
                end
                ST_SH: begin
                    misaligned = off[0];
                    wmask_n    = 4'b0011 << off;
                    wdata_n    = {2{store_data_i[15:0]}};
                end
                ST_SW: begin
                    misaligned = (off != 2'b00);
                    wmask_n    = 4'b1111;
                    wdata_n    = store_data_i;
                end
                default: unsupported = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                LD_LB, LD_LBU: misaligned = 1'b0;
                LD_LH, LD_LHU: misaligned = off[0];
                LD_LW:         misaligned = (off != 2'b00);
                default:       unsupported = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        stall_o = 1'b0;
        accept  = 1'b0;
        finish  = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE: begin
                if (req && !bad) begin
                    stall_o = 1'b1;
                    accept  = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                stall_o = 1'b1;
                if (dmem_resp) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end else if (tmo_hit) begin
                    timeout = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign done_o = (state == DONE);
    assign err_o  = ((state == IDLE) && req && bad) || ((state == DONE) && tmo_err);

    lsu_load_align u_align (
        .rdata  (dmem_rdata),
        .offset (off_q),
        .funct3 (funct3_q),
        .data   (aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_address <= 32'b0;
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            dmem_wmask   <= 4'b0;
            dmem_wdata   <= 32'b0;
            load_data_o  <= 32'b0;
            tmo_cnt      <= 32'b0;
            tmo_err      <= 1'b0;
            funct3_q     <= 3'b0;
            off_q        <= 2'b0;
        end else begin
            if (accept) begin
                dmem_address <= {addr_i[31:2], 2'b00};
                dmem_read    <= ~mem_write_i;
                dmem_write   <= mem_write_i;
                dmem_wmask   <= wmask_n;
                dmem_wdata   <= wdata_n;
                funct3_q     <= funct3_i;
                off_q        <= off;
                tmo_cnt      <= 32'b0;
                tmo_err      <= 1'b0;
            end
            if (state == REQ) tmo_cnt <= tmo_cnt + 32'd1;
            if (finish || timeout) begin
                dmem_read   <= 1'b0;
                dmem_write  <= 1'b0;
                tmo_err     <= timeout;
                load_data_o <= (finish && !dmem_write) ? aligned : 32'b0;
            end
        end
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Load/store unit for the MEM pipeline stage. It consumes the memory fields of rv32i_control_word (mem_read, mem_write, funct3) plus the computed address and rs2 data, and acts as initiator on the data-memory port. It word-aligns the address, builds the write mask and replicated write data, and holds the pipeline stalled until the memory response arrives. It returns sign- or zero-extended load data to the writeback path.

Parameters:
TIMEOUT_CYCLES, 0, maximum cycles spent in REQ waiting for dmem_resp; 0 disables the timeout.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
valid_i  in  1  MEM stage holds a live instruction
mem_read_i  in  1  control word mem_read
mem_write_i  in  1  control word mem_write
funct3_i  in  3  control word funct3 (load_funct3_t / store_funct3_t encoding)
addr_i  in  32  effective address from the ALU
store_data_i  in  32  rs2 value
dmem_address  out  32  word-aligned address {addr[31:2],2'b00}
dmem_read  out  1  read request, registered
dmem_write  out  1  write request, registered
dmem_wmask  out  4  byte enables, registered
dmem_wdata  out  32  write data, registered
dmem_rdata  in  32  read data, valid when dmem_resp=1
dmem_resp  in  1  one-cycle completion pulse
stall_o  out  1  freeze the pipeline
load_data_o  out  32  extended load result, valid when done_o=1
done_o  out  1  one-cycle pulse: access finished
err_o  out  1  misaligned access, unsupported funct3, or timeout

Behaviour:
- Reset values: state IDLE; dmem_read, dmem_write, dmem_wmask, dmem_wdata, dmem_address, load_data_o, done_o, err_o, and the timeout counter are all 0. A reset in REQ drops the request on that same edge.
- Request condition: req = valid_i & (mem_read_i | mem_write_i).
- Bad access, decoded combinationally from funct3_i and addr_i[1:0]:
  - misaligned: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0.
  - unsupported: load funct3 011/110/111; store funct3 >= 011.
- Read and write both asserted: write takes priority and the read is ignored.
- FSM states: IDLE, REQ, DONE.
  - IDLE, req & bad: err_o=1 combinationally, no memory access, stall_o=0, state stays IDLE.
  - IDLE, req & ~bad: stall_o=1; latch address, mask, data, funct3 and addr[1:0]; go to REQ.
  - IDLE, otherwise: stall_o=0.
  - REQ: stall_o=1; dmem_read or dmem_write held high with stable address, mask and data.
  - REQ, dmem_resp=1: drop the request; capture extended rdata into load_data_o (write: load_data_o=0); go to DONE.
  - REQ, timeout: when TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 without resp, drop the request, set the err flag, load_data_o=0, go to DONE.
  - DONE: stall_o=0, done_o=1, err_o=1 only on timeout; unconditionally back to IDLE. The pipeline advances at the end of DONE, so the same instruction is never re-accepted.
- Minimum latency: 3 cycles in MEM (IDLE accept, REQ with same-cycle resp, DONE). Each extra REQ cycle adds one.
- Store formatting:
  - sb: wmask=4'b0001<<off, wdata={4{d[7:0]}}
  - sh: wmask=4'b0011<<off, wdata={2{d[15:0]}}
  - sw: wmask=4'b1111, wdata=d
  - Reads drive wmask=0.
- Load extraction: shifted = rdata>>(8*off).
  - lb: sign-extend shifted[7:0]; lbu: zero-extend.
  - lh: sign-extend shifted[15:0]; lhu: zero-extend.
  - lw: rdata.
- dmem_resp outside REQ is ignored.

Decomposition:
- rv32i_types gains lsu_state_t {IDLE, REQ, DONE}.
- Existing load_funct3_t/store_funct3_t are reused; no new constants.
- One combinational sub-module, lsu_load_align (rdata, offset, funct3 -> extended word), shared with any future cache-side path.

Test Plan:
- sw addr 0x100, data 0xDEADBEEF, resp in first REQ cycle -> dmem_write=1, wmask 1111, address 0x100; stall_o high for 2 cycles, done_o on cycle 3.
- sb addr 0x103, data 0x000000A5 -> wmask 1000, wdata 0xA5A5A5A5, address 0x100.
- lb addr 0x202, rdata 0x0080FF00, resp after 4 REQ cycles -> load_data_o 0xFFFFFF80 with done_o, stall high for 5 cycles. Same stimulus with lbu -> 0x00000080.
- lh addr 0x301 -> err_o=1 same cycle, dmem_read never asserted, stall_o=0.
- TIMEOUT_CYCLES=8, lw with no resp -> request drops after 8 REQ cycles; next cycle done_o=1, err_o=1, load_data_o=0.
- Reset asserted in the 2nd REQ cycle -> next cycle dmem_read=0, stall_o=0, state IDLE; a following lw completes normally.
